// File: rtl/maze_pose_tracker.sv
// maze_pose_tracker
//   Tracks the absolute pose (x, y, heading) of a maze bot from the relative
//   move stream of the explorer. Each move is checked against the walls the
//   explorer reported. Steps and U-turns are counted. A legal exit or a fault
//   (illegal code, collision, out-of-bounds, timeout) freezes the tracker in a
//   sticky terminal state until reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   move_valid   move/walls valid this cycle
//   move[2:0]    000 hold, 001 fwd, 010 left, 011 right, 100 U-turn
//   walls[2:0]   {left, mid, right} relative walls, 1 = wall
//   move_ready   high while tracking (RUN)
//   pos_x/pos_y  current cell (y = 0 is the north edge)
//   heading      0=N 1=E 2=S 3=W
//   step_count   accepted moves, saturating
//   uturn_count  accepted U-turns, saturating at 255
//   pose_valid   one-cycle pulse the cycle after an accepted move
//   exited       sticky: legal exit taken
//   fault        sticky: fault detected
//   fault_code   0 none, 1 illegal code, 2 collision, 3 out-of-bounds, 4 timeout
module maze_pose_tracker #(
    parameter int GRID_W    = 9,
    parameter int GRID_H    = 9,
    parameter int START_X   = 4,
    parameter int START_Y   = 8,
    parameter int START_DIR = 0,
    parameter int EXIT_X    = 4,
    parameter int EXIT_Y    = 0,
    parameter int EXIT_DIR  = 0,
    parameter int MAX_STEPS = 250,
    parameter int STEP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              move_valid,
    input  logic [2:0]        move,
    input  logic [2:0]        walls,
    output logic              move_ready,
    output logic [3:0]        pos_x,
    output logic [3:0]        pos_y,
    output logic [1:0]        heading,
    output logic [STEP_W-1:0] step_count,
    output logic [7:0]        uturn_count,
    output logic              pose_valid,
    output logic              exited,
    output logic              fault,
    output logic [2:0]        fault_code
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EXITED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [3:0] LAST_X = 4'(GRID_W - 1);
    localparam logic [3:0] LAST_Y = 4'(GRID_H - 1);

    state_t state_reg;

    logic              accept;
    logic              illegal;
    logic              collision;
    logic              moves_cell;
    logic              off_grid;
    logic              exit_ok;
    logic              timeout;
    logic [1:0]        heading_next;
    logic [3:0]        x_next;
    logic [3:0]        y_next;
    logic [STEP_W-1:0] step_next;
    logic [7:0]        uturn_next;

    assign accept = move_valid && (state_reg == ST_RUN);

    always_comb begin
        illegal      = 1'b0;
        collision    = 1'b0;
        moves_cell   = 1'b1;
        heading_next = heading;
        uturn_next   = uturn_count;
        case (move)
            3'b000: moves_cell = 1'b0;
            3'b001: collision = walls[1];
            3'b010: begin
                heading_next = heading - 2'd1;
                collision    = walls[2];
            end
            3'b011: begin
                heading_next = heading + 2'd1;
                collision    = walls[0];
            end
            3'b100: begin
                heading_next = heading + 2'd2;
                if (uturn_count != 8'hFF) begin
                    uturn_next = uturn_count + 8'd1;
                end
            end
            default: begin
                illegal    = 1'b1;
                moves_cell = 1'b0;
            end
        endcase

        // Translation uses the heading after the turn has been applied.
        x_next   = pos_x;
        y_next   = pos_y;
        off_grid = 1'b0;
        if (moves_cell) begin
            case (heading_next)
                DIR_N: begin
                    off_grid = (pos_y == 4'd0);
                    y_next   = pos_y - 4'd1;
                end
                DIR_E: begin
                    off_grid = (pos_x == LAST_X);
                    x_next   = pos_x + 4'd1;
                end
                DIR_S: begin
                    off_grid = (pos_y == LAST_Y);
                    y_next   = pos_y + 4'd1;
                end
                DIR_W: begin
                    off_grid = (pos_x == 4'd0);
                    x_next   = pos_x - 4'd1;
                end
                default: off_grid = 1'b0;
            endcase
        end

        exit_ok = off_grid && (pos_x == 4'(EXIT_X)) && (pos_y == 4'(EXIT_Y))
                  && (heading_next == 2'(EXIT_DIR));

        step_next = step_count;
        if (step_count != {STEP_W{1'b1}}) begin
            step_next = step_count + 1'b1;
        end
        timeout = (step_next == STEP_W'(MAX_STEPS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            pos_x       <= 4'(START_X);
            pos_y       <= 4'(START_Y);
            heading     <= 2'(START_DIR);
            step_count  <= '0;
            uturn_count <= '0;
            pose_valid  <= 1'b0;
            exited      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            move_ready  <= 1'b1;
        end else begin
            pose_valid <= accept;
            if (accept) begin
                // Counters include the move that ends the run.
                step_count  <= step_next;
                uturn_count <= uturn_next;
                // Terminal outcomes keep the pre-move pose.
                if (illegal) begin
                    state_reg  <= ST_FAULT;
                    fault      <= 1'b1;
                    fault_code <= 3'd1;
                    move_ready <= 1'b0;
                end else if (collision) begin
                    state_reg  <= ST_FAULT;
                    fault      <= 1'b1;
                    fault_code <= 3'd2;
                    move_ready <= 1'b0;
                end else if (exit_ok) begin
                    state_reg  <= ST_EXITED;
                    exited     <= 1'b1;
                    move_ready <= 1'b0;
                end else if (off_grid) begin
                    state_reg  <= ST_FAULT;
                    fault      <= 1'b1;
                    fault_code <= 3'd3;
                    move_ready <= 1'b0;
                end else if (timeout) begin
                    state_reg  <= ST_FAULT;
                    fault      <= 1'b1;
                    fault_code <= 3'd4;
                    move_ready <= 1'b0;
                end else begin
                    pos_x   <= x_next;
                    pos_y   <= y_next;
                    heading <= heading_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_pose_tracker.sv
module tb_maze_pose_tracker;

    logic       clk;
    logic       rst_n;
    logic       move_valid;
    logic [2:0] move;
    logic [2:0] walls;

    logic       move_ready, pose_valid, exited, fault;
    logic [3:0] pos_x, pos_y;
    logic [1:0] heading;
    logic [7:0] step_count, uturn_count;
    logic [2:0] fault_code;

    // Second instance with a tiny step budget for the timeout case.
    logic       t_move_ready, t_pose_valid, t_exited, t_fault;
    logic [3:0] t_pos_x, t_pos_y;
    logic [1:0] t_heading;
    logic [7:0] t_step_count, t_uturn_count;
    logic [2:0] t_fault_code;

    int n_cmp = 0;
    int n_bad = 0;

    maze_pose_tracker dut (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move(move), .walls(walls),
        .move_ready(move_ready), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
        .step_count(step_count), .uturn_count(uturn_count), .pose_valid(pose_valid),
        .exited(exited), .fault(fault), .fault_code(fault_code)
    );

    maze_pose_tracker #(.MAX_STEPS(5)) dut_to (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move(move), .walls(walls),
        .move_ready(t_move_ready), .pos_x(t_pos_x), .pos_y(t_pos_y), .heading(t_heading),
        .step_count(t_step_count), .uturn_count(t_uturn_count), .pose_valid(t_pose_valid),
        .exited(t_exited), .fault(t_fault), .fault_code(t_fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rst;
        logic [2:0] mv;
        logic [2:0] wl;
        int         x, y, hd, st, ut;
        bit         pv, rdy, ex, flt;
        int         code;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit r, logic [2:0] mv, logic [2:0] wl, int x, int y, int hd,
                       int st, int ut, bit pv, bit rdy, bit ex, bit flt, int code);
        vec_t v;
        v.rst = r; v.mv = mv; v.wl = wl; v.x = x; v.y = y; v.hd = hd; v.st = st; v.ut = ut;
        v.pv = pv; v.rdy = rdy; v.ex = ex; v.flt = flt; v.code = code;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {31'd0, pos_x, pos_y, heading, step_count, uturn_count,
                pose_valid, move_ready, exited, fault, fault_code};
    endfunction

    function automatic logic [63:0] pack_exp(vec_t v);
        return {31'd0, 4'(v.x), 4'(v.y), 2'(v.hd), 8'(v.st), 8'(v.ut),
                v.pv, v.rdy, v.ex, v.flt, 3'(v.code)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        move_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one move for one clock edge; outputs are sampled at the next negedge.
    task automatic apply(logic [2:0] mv, logic [2:0] wl);
        @(negedge clk);
        move = mv;
        walls = wl;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        move_valid = 1'b0;
        move = 3'd0;
        walls = 3'd0;

        //  r  mv      wl      x  y  hd st ut pv rdy ex flt code
        // basic moves, U-turn ignores walls
        add(1, 3'b001, 3'b000, 4, 7, 0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 3'b011, 3'b000, 5, 7, 1, 2, 0, 1, 1, 0, 0, 0);
        add(0, 3'b001, 3'b000, 6, 7, 1, 3, 0, 1, 1, 0, 0, 0);
        add(0, 3'b100, 3'b111, 5, 7, 3, 4, 1, 1, 1, 0, 0, 0);
        add(0, 3'b000, 3'b111, 5, 7, 3, 5, 1, 1, 1, 0, 0, 0);
        // left into a wall, then ignored input
        add(1, 3'b010, 3'b100, 4, 8, 0, 1, 0, 1, 0, 0, 1, 2);
        add(0, 3'b001, 3'b000, 4, 8, 0, 1, 0, 0, 0, 0, 1, 2);
        // forward into a mid wall
        add(1, 3'b001, 3'b010, 4, 8, 0, 1, 0, 1, 0, 0, 1, 2);
        // illegal code has priority over walls
        add(1, 3'b101, 3'b111, 4, 8, 0, 1, 0, 1, 0, 0, 1, 1);
        add(1, 3'b111, 3'b000, 4, 8, 0, 1, 0, 1, 0, 0, 1, 1);
        // exit via left turn from heading E at (4,0)
        add(1, 3'b001, 3'b000, 4, 7, 0, 1, 0, 1, 1, 0, 0, 0);
        for (int k = 2; k <= 7; k++) add(0, 3'b001, 3'b000, 4, 8 - k, 0, k, 0, 1, 1, 0, 0, 0);
        add(0, 3'b010, 3'b000, 3, 1, 3, 8, 0, 1, 1, 0, 0, 0);
        add(0, 3'b011, 3'b000, 3, 0, 0, 9, 0, 1, 1, 0, 0, 0);
        add(0, 3'b011, 3'b000, 4, 0, 1, 10, 0, 1, 1, 0, 0, 0);
        add(0, 3'b010, 3'b000, 4, 0, 1, 11, 0, 1, 0, 1, 0, 0);
        add(0, 3'b001, 3'b000, 4, 0, 1, 11, 0, 0, 0, 1, 0, 0);
        // exit via right turn from heading W at (4,0)
        add(1, 3'b001, 3'b000, 4, 7, 0, 1, 0, 1, 1, 0, 0, 0);
        for (int k = 2; k <= 7; k++) add(0, 3'b001, 3'b000, 4, 8 - k, 0, k, 0, 1, 1, 0, 0, 0);
        add(0, 3'b011, 3'b000, 5, 1, 1, 8, 0, 1, 1, 0, 0, 0);
        add(0, 3'b010, 3'b000, 5, 0, 0, 9, 0, 1, 1, 0, 0, 0);
        add(0, 3'b010, 3'b000, 4, 0, 3, 10, 0, 1, 1, 0, 0, 0);
        add(0, 3'b011, 3'b000, 4, 0, 3, 11, 0, 1, 0, 1, 0, 0);
        // off the west edge at (0,8)
        add(1, 3'b010, 3'b000, 3, 8, 3, 1, 0, 1, 1, 0, 0, 0);
        add(0, 3'b001, 3'b000, 2, 8, 3, 2, 0, 1, 1, 0, 0, 0);
        add(0, 3'b001, 3'b000, 1, 8, 3, 3, 0, 1, 1, 0, 0, 0);
        add(0, 3'b001, 3'b000, 0, 8, 3, 4, 0, 1, 1, 0, 0, 0);
        add(0, 3'b001, 3'b000, 0, 8, 3, 5, 0, 1, 0, 0, 1, 3);
        // off the south edge at the start cell
        add(1, 3'b100, 3'b000, 4, 8, 0, 1, 1, 1, 0, 0, 1, 3);

        // Reset state after idling
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", pack_out(), {31'd0, 4'd4, 4'd8, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].mv, vecs[i].wl);
            $display("vec%0d move=%b walls=%b -> pos=(%0d,%0d) hd=%0d steps=%0d code=%0d",
                     i, vecs[i].mv, vecs[i].wl, pos_x, pos_y, heading, step_count, fault_code);
            chk($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
        end

        // pose_valid is exactly one cycle wide
        do_reset();
        apply(3'b001, 3'b000);
        chk("pv_high", {63'd0, pose_valid}, 64'd1);
        @(negedge clk);
        chk("pv_low", {63'd0, pose_valid}, 64'd0);
        $display("pulse check pv=%b", pose_valid);

        // Timeout on the fifth accepted move with MAX_STEPS=5
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            apply(3'b000, 3'b000);
            $display("hold %0d: timeout-dut steps=%0d fault=%b code=%0d",
                     k, t_step_count, t_fault, t_fault_code);
            if (k == 4) chk("to_before", {61'd0, t_fault, t_fault_code[1:0]}, 64'd0);
        end
        chk("to_fault", {55'd0, t_step_count, t_fault, t_fault_code},
            {55'd0, 8'd5, 1'b1, 3'd4});
        chk("to_pose", {54'd0, t_pos_x, t_pos_y, t_heading}, {54'd0, 4'd4, 4'd8, 2'd0});
        chk("to_ready", {63'd0, t_move_ready}, 64'd0);
        chk("main_steps5", pack_out(), {31'd0, 4'd4, 4'd8, 2'd0, 8'd5, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0});

        // Asynchronous reset mid-run discards the pending move
        do_reset();
        apply(3'b001, 3'b000);
        apply(3'b100, 3'b000);
        @(negedge clk);
        move = 3'b001;
        walls = 3'b000;
        move_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: pos=(%0d,%0d) steps=%0d uturns=%0d", pos_x, pos_y, step_count, uturn_count);
        chk("async_reset", pack_out(), {31'd0, 4'd4, 4'd8, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        move_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", pack_out(), {31'd0, 4'd4, 4'd8, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
